wb_arbiter2: RTL and testbench
==============================

Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone classic arbiter in front of the unified instruction/data memory.
- Master 0 is the multicycle core's bus port (fetch and load/store). Master 1 is a secondary requester, such as the debug/loader port or a DMA.
- Round-robin arbitration. Ownership is locked for the whole cyc_o assertion. A stall watchdog returns err to a master whose slave never acks.

Parameters:
- AW, 32, address width.
- DW, 32, data width; SEL width is DW/8.
- TIMEOUT_CYCLES, 255, stalled-strobe cycles before err is returned. 0 disables the watchdog.
- CW, 8, watchdog counter width. Must satisfy 2^CW > TIMEOUT_CYCLES.

Ports:
- wb_clk  in  1  bus clock, rising edge.
- wb_rst_n  in  1  reset, asynchronous and active-low.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle, strobe, write enable.
- m0_adr_i  in  AW  master 0 address.
- m0_dat_i  in  DW  master 0 write data.
- m0_sel_i  in  DW/8  master 0 byte selects.
- m0_dat_o  out  DW  read data to master 0.
- m0_ack_o, m0_err_o  out  1 each  acknowledge and error to master 0.
- m1_*  same set as m0_*  master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle, strobe, write enable.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_sel_o  out  DW/8  slave byte selects.
- s_dat_i  in  DW  slave read data.
- s_ack_i  in  1  slave acknowledge.
- grant_o  out  2  one-hot owner: bit0 is m0, bit1 is m1, 00 is idle.

Behaviour:

Reset
- wb_rst_n low asynchronously forces:
  - state IDLE and grant_o 00;
  - last_owner = 1, so m0 wins the first tie;
  - watchdog counter 0.
- All outputs are 0 while reset is held, including m*_ack_o, m*_err_o and m*_dat_o.
- Reset mid-transaction abandons the transfer; no ack or err is delivered.

States (registered): IDLE, OWN0, OWN1.

IDLE
- Exactly one mN_cyc_i high: go to OWNN next edge.
- Both high: grant the master that is not last_owner.
- Arbitration latency is 1 cycle; the slave first sees the request on the cycle after the grant edge.

OWNN
- Hold while mN_cyc_i is high. The other master's requests are ignored, which keeps bursts and read-modify-write locked.
- When mN_cyc_i is sampled low:
  - other master's cyc high: go directly to OWNother, with no idle cycle;
  - otherwise go to IDLE;
  - in both cases set last_owner = N.

Muxing (combinational from the registered grant)
- While granted: s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o and s_sel_o equal the owner's inputs.
- In IDLE: all slave outputs are 0.
- s_cyc_o is gated by the owner's live cyc. When the owner drops cyc, the slave sees it drop in the same cycle, before the state update.

Return path
- m0_dat_o and m1_dat_o both carry s_dat_i.
- mN_ack_o = s_ack_i AND owner==N AND mN_cyc_i.
- The non-owner never sees ack or err.
- s_ack_i in IDLE is ignored.

Watchdog
- Counter increments each cycle with s_cyc_o & s_stb_o & ~s_ack_i.
- It clears on s_ack_i, on stb low, and on any change of owner.
- On the cycle the count equals TIMEOUT_CYCLES-1 while still stalled:
  - mN_err_o pulses for 1 cycle, so err lands on the TIMEOUT_CYCLESth stalled cycle;
  - the counter clears.
- Ownership is unchanged; the master is expected to drop cyc.
- s_ack_i in the err cycle wins: ack is delivered, err is suppressed, the counter clears.
- ack and err are never high together.
- The counter saturates rather than wraps. With TIMEOUT_CYCLES=0, err is never asserted.

Timing
- No combinational path from s_ack_i to any s_* output.
- The input-to-slave path is a mux only.

Test Plan:
- m0-only read:
  - stimulus: m0 cyc/stb at cycle 0, adr 0x100; slave acks at cycle 3 with 0xDEADBEEF;
  - required: grant_o=01 from cycle 1, s_adr_o=0x100, m0_ack_o and m0_dat_o=0xDEADBEEF at cycle 3, m1_ack_o=0.
- Tie after reset:
  - stimulus: m0 and m1 assert cyc on the same cycle;
  - required: OWN0 first. The cycle after m0 drops cyc, grant_o=10 with no IDLE cycle, and s_adr_o follows m1.
- Round-robin:
  - stimulus: both masters issue single-beat transfers back to back, each re-raising cyc the cycle after its ack;
  - required: grant sequence 01,10,01,10; no master is granted twice in a row while the other waits.
- Lock:
  - stimulus: m0 holds cyc through 4 acked beats (adr 0x0,0x4,0x8,0xC); m1 requests after beat 1;
  - required: m1 is not granted until the cycle after m0 cyc falls; all 4 m0 acks seen; zero m1 acks during the burst.
- Watchdog (TIMEOUT_CYCLES=8):
  - stimulus 1: slave never acks m1;
  - required 1: m1_err_o is a single pulse on the 8th stalled cycle; m0_err_o=0.
  - stimulus 2: slave acks exactly on that 8th cycle;
  - required 2: m1_ack_o=1, m1_err_o=0.
- Async reset mid-transfer:
  - stimulus: drop wb_rst_n between clock edges during OWN1;
  - required: s_cyc_o, grant_o and all acks go to 0 immediately. After release, a tie grants m0.

Source files
------------

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master round-robin Wishbone classic arbiter with stall watchdog
// Ownership is held for the whole owner cyc; the slave-side mux is driven purely from the registered grant.
module wb_arbiter2 #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CW             = 8
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,

  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW-1:0]     m0_dat_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  output logic [DW-1:0]     m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,

  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  output logic [DW-1:0]     m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,

  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  output logic [DW/8-1:0]   s_sel_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,

  output logic [1:0]        grant_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam bit            WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] WD_LAST = CW'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t        state;
  logic          last_owner;
  logic [CW-1:0] wd_cnt;
  logic          owner_change;
  logic          stalled;
  logic          wd_fire;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state      <= IDLE;
      grant_o    <= 2'b00;
      last_owner <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // On a tie the master that did not own the bus last wins.
          if (m0_cyc_i && (!m1_cyc_i || last_owner)) begin
            state   <= OWN0;
            grant_o <= 2'b01;
          end else if (m1_cyc_i) begin
            state   <= OWN1;
            grant_o <= 2'b10;
          end
        end
        OWN0: begin
          if (!m0_cyc_i) begin
            last_owner <= 1'b0;
            if (m1_cyc_i) begin
              state   <= OWN1;
              grant_o <= 2'b10;
            end else begin
              state   <= IDLE;
              grant_o <= 2'b00;
            end
          end
        end
        OWN1: begin
          if (!m1_cyc_i) begin
            last_owner <= 1'b1;
            if (m0_cyc_i) begin
              state   <= OWN0;
              grant_o <= 2'b01;
            end else begin
              state   <= IDLE;
              grant_o <= 2'b00;
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    owner_change = 1'b0;
    case (state)
      IDLE:    owner_change = m0_cyc_i | m1_cyc_i;
      OWN0:    owner_change = ~m0_cyc_i;
      OWN1:    owner_change = ~m1_cyc_i;
      default: owner_change = 1'b1;
    endcase
  end

  assign s_cyc_o = (grant_o[0] & m0_cyc_i) | (grant_o[1] & m1_cyc_i);
  assign s_stb_o = (grant_o[0] & m0_stb_i) | (grant_o[1] & m1_stb_i);
  assign s_we_o  = (grant_o[0] & m0_we_i)  | (grant_o[1] & m1_we_i);
  assign s_adr_o = ({AW{grant_o[0]}} & m0_adr_i) | ({AW{grant_o[1]}} & m1_adr_i);
  assign s_dat_o = ({DW{grant_o[0]}} & m0_dat_i) | ({DW{grant_o[1]}} & m1_dat_i);
  assign s_sel_o = ({(DW/8){grant_o[0]}} & m0_sel_i) | ({(DW/8){grant_o[1]}} & m1_sel_i);

  // Ack in the would-be timeout cycle is not a stall, so ack naturally wins over err.
  assign stalled = s_cyc_o & s_stb_o & ~s_ack_i;
  assign wd_fire = WD_EN && stalled && (wd_cnt == WD_LAST);

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wd_cnt <= '0;
    end else if (owner_change || !stalled || wd_fire) begin
      wd_cnt <= '0;
    end else if (wd_cnt != {CW{1'b1}}) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign m0_ack_o = s_ack_i & grant_o[0] & m0_cyc_i;
  assign m1_ack_o = s_ack_i & grant_o[1] & m1_cyc_i;
  assign m0_err_o = wd_fire & grant_o[0];
  assign m1_err_o = wd_fire & grant_o[1];
  assign m0_dat_o = {DW{wb_rst_n}} & s_dat_i;
  assign m1_dat_o = {DW{wb_rst_n}} & s_dat_i;

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - scoreboard bench for wb_arbiter2 against a per-cycle reference model
module tb_wb_arbiter2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int T  = 8;

  typedef struct packed {
    logic [1:0]    grant;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic [SW-1:0] sel;
    logic [1:0]    ack;
    logic [1:0]    err;
    logic [DW-1:0] rdat0;
    logic [DW-1:0] rdat1;
  } exp_t;

  logic          wb_clk = 1'b0;
  logic          wb_rst_n;
  logic          cyc [2];
  logic          stb [2];
  logic          we  [2];
  logic [AW-1:0] adr [2];
  logic [DW-1:0] wdat[2];
  logic [SW-1:0] sel [2];
  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel_o;
  logic [DW-1:0] s_rdat;
  logic          s_ack;
  logic [1:0]    grant_o;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];

  int own   = -1;
  int last  = 1;
  int stall = 0;

  logic [1:0]    o_grant, o_ack, o_err;
  logic          o_cyc;
  logic [AW-1:0] o_adr;
  logic [DW-1:0] o_rdat0, o_rdat1;

  always #5 wb_clk = ~wb_clk;

  wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(T), .CW(8)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]),
    .m0_dat_i(wdat[0]), .m0_sel_i(sel[0]), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]),
    .m1_dat_i(wdat[1]), .m1_sel_i(sel[1]), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_rdat), .s_ack_i(s_ack),
    .grant_o(grant_o)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Reference model: owner as an integer, stall as a run length of consecutive stalled cycles.
  function automatic logic model_req();
    return (own >= 0) && cyc[own] && stb[own];
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    e = '0;
    e.rdat0 = s_rdat;
    e.rdat1 = s_rdat;
    if (own >= 0) begin
      e.grant = (own == 0) ? 2'b01 : 2'b10;
      e.cyc   = cyc[own];
      e.stb   = stb[own];
      e.we    = we[own];
      e.adr   = adr[own];
      e.wdat  = wdat[own];
      e.sel   = sel[own];
      if (cyc[own]) begin
        e.ack[own] = s_ack;
        if (stb[own] && !s_ack && (stall + 1 == T)) e.err[own] = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic void model_advance();
    logic st;
    int   nxt;
    st  = model_req() && !s_ack;
    nxt = own;
    if (own < 0) begin
      if (cyc[0] && cyc[1]) nxt = (last == 0) ? 1 : 0;
      else if (cyc[0])      nxt = 0;
      else if (cyc[1])      nxt = 1;
    end else if (!cyc[own]) begin
      last = own;
      nxt  = cyc[1 - own] ? 1 - own : -1;
    end
    if (nxt != own || !st || (stall + 1 == T)) stall = 0;
    else if (stall < 255) stall = stall + 1;
    own = nxt;
  endfunction

  function automatic void model_reset();
    own = -1; last = 1; stall = 0;
  endfunction

  // Entered and left at posedge+1; inputs are set by the caller before the call.
  task automatic step(input logic sack, input logic [DW-1:0] sdat, output exp_t e);
    s_ack  = sack;
    s_rdat = sdat;
    e = model_eval();
    sbq.push_back(e);
    model_advance();
    #1;
    o_grant = grant_o;
    o_cyc   = s_cyc_o;
    o_adr   = s_adr_o;
    o_ack   = {m1_ack_o, m0_ack_o};
    o_err   = {m1_err_o, m0_err_o};
    o_rdat0 = m0_dat_o;
    o_rdat1 = m1_dat_o;
    @(posedge wb_clk);
    #1;
  endtask

  task automatic set_master(input int n, input logic c, input logic [AW-1:0] a);
    cyc[n]  = c;
    stb[n]  = c;
    we[n]   = 1'b0;
    adr[n]  = a;
    wdat[n] = $urandom;
    sel[n]  = 4'hF;
  endtask

  task automatic new_beat(input int n);
    adr[n]  = $urandom;
    we[n]   = 1'($urandom_range(0, 1));
    wdat[n] = $urandom;
    sel[n]  = 4'($urandom_range(0, 15));
  endtask

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(negedge wb_clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        a.grant = grant_o;  a.cyc = s_cyc_o; a.stb = s_stb_o; a.we = s_we_o;
        a.adr   = s_adr_o;  a.wdat = s_dat_o; a.sel = s_sel_o;
        a.ack   = {m1_ack_o, m0_ack_o};
        a.err   = {m1_err_o, m0_err_o};
        a.rdat0 = m0_dat_o; a.rdat1 = m1_dat_o;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL sb t=%0t actual grant=%b cyc=%b stb=%b we=%b adr=%h wdat=%h sel=%h ack=%b err=%b rd=%h/%h required grant=%b cyc=%b stb=%b we=%b adr=%h wdat=%h sel=%h ack=%b err=%b rd=%h/%h",
                   $time, a.grant, a.cyc, a.stb, a.we, a.adr, a.wdat, a.sel, a.ack, a.err, a.rdat0, a.rdat1,
                   e.grant, e.cyc, e.stb, e.we, e.adr, e.wdat, e.sel, e.ack, e.err, e.rdat0, e.rdat1);
        end
      end
    end
  end

  initial begin : stim
    exp_t e;
    int   n_ack0, n_ack1, early, beat;
    logic [1:0] prev_g;
    logic [1:0] g4[4];
    logic [1:0] gseq[$];
    int   beats[2];

    // Reset state with every input asserted
    wb_rst_n = 1'b0;
    set_master(0, 1'b1, 32'h10);
    set_master(1, 1'b1, 32'h20);
    s_ack  = 1'b1;
    s_rdat = 32'hFFFF_FFFF;
    repeat (2) @(posedge wb_clk);
    #1;
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_scyc", s_cyc_o, 1'b0);
    chk("rst_ack", {m1_ack_o, m0_ack_o}, 2'b00);
    chk("rst_err", {m1_err_o, m0_err_o}, 2'b00);
    chk("rst_dat0", m0_dat_o, 32'h0);
    chk("rst_dat1", m1_dat_o, 32'h0);
    set_master(0, 1'b0, 0);
    set_master(1, 1'b0, 0);
    s_ack = 1'b0;
    #2 wb_rst_n = 1'b1;
    @(posedge wb_clk);
    #1;
    model_reset();

    // m0-only read
    set_master(0, 1'b1, 32'h100);
    step(1'b0, 32'h0, e);
    chk("rd_idle_grant", o_grant, 2'b00);
    step(1'b0, 32'h0, e);
    chk("rd_grant", o_grant, 2'b01);
    chk("rd_sadr", o_adr, 32'h100);
    step(1'b0, 32'h0, e);
    step(1'b1, 32'hDEADBEEF, e);
    chk("rd_ack0", o_ack[0], 1'b1);
    chk("rd_dat0", o_rdat0, 32'hDEADBEEF);
    chk("rd_ack1", o_ack[1], 1'b0);
    set_master(0, 1'b0, 0);
    step(1'b0, 32'h0, e);

    // Lock: 4-beat m0 burst, m1 requests after beat 1
    set_master(0, 1'b1, 32'h0);
    beat = 0; n_ack0 = 0; n_ack1 = 0; early = 0;
    for (int c = 0; c < 20 && beat < 4; c++) begin
      adr[0] = 32'(beat * 4);
      step(model_req(), $urandom, e);
      if (o_ack[0]) n_ack0++;
      if (o_ack[1]) n_ack1++;
      if (o_grant == 2'b10) early++;
      if (e.ack[0]) begin
        beat++;
        if (beat == 1) set_master(1, 1'b1, 32'h200);
      end
    end
    chk("lock_acks0", 64'(n_ack0), 64'd4);
    chk("lock_acks1", 64'(n_ack1), 64'd0);
    chk("lock_early", 64'(early), 64'd0);
    set_master(0, 1'b0, 0);
    step(model_req(), $urandom, e);
    chk("lock_hold", o_grant, 2'b01);
    step(model_req(), 32'h1234_5678, e);
    chk("lock_m1_grant", o_grant, 2'b10);
    chk("lock_m1_adr", o_adr, 32'h200);
    chk("lock_m1_ack", o_ack, 2'b10);
    set_master(1, 1'b0, 0);
    step(1'b0, 32'h0, e);

    // Watchdog: slave never acks m1
    set_master(1, 1'b1, 32'h300);
    step(1'b0, 32'h0, e);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 32'h0, e);
      chk($sformatf("wd_err1_k%0d", k), o_err[1], (k == T));
      chk($sformatf("wd_err0_k%0d", k), o_err[0], 1'b0);
    end
    set_master(1, 1'b0, 0);
    step(1'b0, 32'h0, e);

    // Watchdog: ack lands exactly on the timeout cycle
    set_master(1, 1'b1, 32'h304);
    step(1'b0, 32'h0, e);
    for (int k = 1; k < T; k++) step(1'b0, 32'h0, e);
    step(1'b1, 32'hA5A5_5A5A, e);
    chk("wd_ackwin_ack", o_ack[1], 1'b1);
    chk("wd_ackwin_err", o_err[1], 1'b0);
    set_master(1, 1'b0, 0);
    step(1'b0, 32'h0, e);

    // Asynchronous reset during OWN1
    set_master(1, 1'b1, 32'h400);
    step(1'b0, 32'h0, e);
    step(1'b0, 32'h0, e);
    s_ack  = 1'b1;
    s_rdat = 32'hCAFE_F00D;
    #2 wb_rst_n = 1'b0;
    #1;
    chk("arst_scyc", s_cyc_o, 1'b0);
    chk("arst_grant", grant_o, 2'b00);
    chk("arst_ack", {m1_ack_o, m0_ack_o}, 2'b00);
    chk("arst_dat1", m1_dat_o, 32'h0);
    set_master(1, 1'b0, 0);
    s_ack = 1'b0;
    repeat (2) @(posedge wb_clk);
    #3 wb_rst_n = 1'b1;
    @(posedge wb_clk);
    #1;
    model_reset();

    // Tie after reset, then a direct hand-over to m1
    set_master(0, 1'b1, 32'h500);
    set_master(1, 1'b1, 32'h600);
    step(1'b0, 32'h0, e);
    step(1'b1, 32'h1111_2222, e);
    chk("tie_grant", o_grant, 2'b01);
    chk("tie_ack0", o_ack, 2'b01);
    set_master(0, 1'b0, 0);
    step(1'b0, 32'h0, e);
    chk("tie_drop_scyc", o_cyc, 1'b0);
    step(1'b0, 32'h0, e);
    chk("tie_handover", o_grant, 2'b10);
    chk("tie_m1_adr", o_adr, 32'h600);
    set_master(1, 1'b0, 0);
    step(1'b0, 32'h0, e);

    // Round-robin with single-beat masters re-raising cyc one cycle after ack
    set_master(0, 1'b1, 32'h700);
    set_master(1, 1'b1, 32'h800);
    prev_g = 2'b00;
    for (int c = 0; c < 12; c++) begin
      step(model_req(), $urandom, e);
      if (o_grant != prev_g && o_grant != 2'b00) gseq.push_back(o_grant);
      prev_g = o_grant;
      for (int n = 0; n < 2; n++) begin
        if (e.ack[n]) begin cyc[n] = 1'b0; stb[n] = 1'b0; end
        else if (!cyc[n]) begin cyc[n] = 1'b1; stb[n] = 1'b1; end
      end
    end
    for (int i = 0; i < 4; i++) g4[i] = (i < gseq.size()) ? gseq[i] : 2'b00;
    chk("rr_g0", g4[0], 2'b01);
    chk("rr_g1", g4[1], 2'b10);
    chk("rr_g2", g4[2], 2'b01);
    chk("rr_g3", g4[3], 2'b10);
    set_master(0, 1'b0, 0);
    set_master(1, 1'b0, 0);
    step(1'b0, 32'h0, e);
    step(1'b0, 32'h0, e);

    // Randomized traffic with dead-slave windows, checked by the scoreboard
    beats[0] = 0;
    beats[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      logic sack;
      for (int n = 0; n < 2; n++) begin
        if (!cyc[n] && $urandom_range(0, 3) == 0) begin
          cyc[n]   = 1'b1;
          beats[n] = $urandom_range(1, 3);
          new_beat(n);
        end
        stb[n] = cyc[n] && ($urandom_range(0, 7) != 0);
      end
      if ((c % 400) < 60) sack = 1'b0;
      else if (model_req()) sack = ($urandom_range(0, 2) == 0);
      else sack = ($urandom_range(0, 7) == 0);
      step(sack, $urandom, e);
      for (int n = 0; n < 2; n++) begin
        if (e.ack[n] || e.err[n]) begin
          beats[n]--;
          if (e.err[n] || beats[n] == 0) begin cyc[n] = 1'b0; stb[n] = 1'b0; end
          else new_beat(n);
        end
      end
    end
    set_master(0, 1'b0, 0);
    set_master(1, 1'b0, 0);
    step(1'b0, 32'h0, e);
    step(1'b0, 32'h0, e);
    chk("sb_drain", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
